slider_moves: RTL and testbench
===============================

# slider_moves

Parametrised sliding/stepping-piece move generator for the DE1 chess accelerator. Successor to the single-piece accelerator stubs: same CPU-facing Avalon-MM slave and SDRAM-facing Avalon-MM master. The CPU programs a board base address, an output buffer address, a source square, piece mode and side colour, then starts the block. It walks up to eight rays over the SDRAM board image, writes each pseudo-legal move to the output buffer, and reports the count.

## Interface
Parameters:
- BOARD_W, 8: board side; squares = BOARD_W*BOARD_W; SQ_W = $clog2(BOARD_W*BOARD_W)
- MAX_MOVES, 32: output buffer capacity in moves; generation stops at this count

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-high (level 1 resets on the rising clk edge)
- slave_waitrequest  out  1  tied 0
- slave_address  in  4  word register index
- slave_read  in  1  register read strobe
- slave_readdata  out  32  register data, combinational from slave_address
- slave_write  in  1  register write strobe
- slave_writedata  in  32  register write data
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  byte address
- master_read  out  1  read request
- master_readdata  in  32  read data
- master_readdatavalid  in  1  read data qualifier
- master_write  out  1  write request
- master_writedata  out  32  write data

## Operation
- Registers: 0 CTRL/STATUS: write bit0=1 starts; read {29'b0, overflow, done, busy}. 1 BOARD_BASE. 2 OUT_BASE. 3 CFG: [SQ_W-1:0] square, [9:8] mode (0 rook, 1 bishop, 2 queen, 3 king), [12] own colour (0 white, 1 black). 4 COUNT, read-only. 5 CYCLES (see Configuration). Others read 0; writes to them are ignored.
- Writes to 1–3 are ignored while busy. Start while busy is ignored. Start clears done and overflow, zeroes COUNT, and sets busy.
- Board word for square s sits at BOARD_BASE + 4*s. s = row*BOARD_W + col. Word == 0 means empty. Otherwise bit3 is piece colour.
- Direction order: N(row+1), NE, E(col+1), SE, S, SW, W, NW. Rook uses N/E/S/W, bishop the diagonals, queen and king all eight. King takes at most one step per ray.
- Per ray, step from the source: off-board → next ray. Read target word. Empty → emit. Enemy colour → emit with capture, end ray. Own colour → end ray, no emit.
- Emit: write {15'b0, capture, (8-SQ_W)'b0 pad, from[7:0]... } as follows: word[7:0]=to, [15:8]=from, [16]=capture, rest 0. Address is OUT_BASE + 4*COUNT. Then COUNT increments.
- COUNT reaching MAX_MOVES after an emit → overflow=1; go to DONE immediately.
- FSM: IDLE → NEXT_DIR (choose next ray in mode set, or DONE if exhausted) → STEP (advance coords, bounds check) → RD_REQ → RD_WAIT → (WR_REQ → STEP/NEXT_DIR) or NEXT_DIR. DONE sets done=1 and busy=0, then → IDLE.

## Timing
- Reset values: master_read=0, master_write=0, master_address=0, master_writedata=0, slave_readdata reflects zeroed registers, busy=done=overflow=0, COUNT=0, FSM=IDLE.
- Reset asserted mid-operation: all master strobes drop at that edge. The block abandons outstanding transfers and ignores any later readdatavalid.
- Master read: address and read held constant until the cycle master_waitrequest=0. Data is captured on the first master_readdatavalid after that. One read is outstanding at most.
- Master write: address, data and write held until master_waitrequest=0. Exactly one write per emit.
- Zero-wait SDRAM, minimum per square: STEP 1 + RD_REQ 1 + RD_WAIT ≥1 (+WR_REQ 1 on emit).
- Start takes effect the edge after the slave write. busy is readable as 1 the following cycle.

## Configuration
- SLIDER_PERF_CNT_EN defined: register 5 is a 32-bit counter. It is cleared on start, increments every cycle busy=1, and holds after done.
- Undefined: register 5 reads 0 and no counter logic exists.

## Test plan
- Rook, sq 0, white, empty 8x8 board, zero-wait SDRAM → COUNT=14, done=1, overflow=0, first write word 0x00000008 at OUT_BASE, no capture bits.
- Queen, sq 27, empty board → COUNT=27, 27 writes, 27 reads, moves ordered by ray N…NW.
- Rook, sq 0, white; black piece (0x8) at sq 8, white piece (0x1) at sq 1 → COUNT=1, word 0x00010008.
- MAX_MOVES=8, queen sq 27, empty → COUNT=8, overflow=1, exactly 8 writes, no further master traffic.
- King sq 0 with random master_waitrequest stalls → COUNT=3 (to 8, 9, 1). Strobes and address stay stable during every stall.
- rst_n pulsed high while RD_WAIT → next cycle all outputs at reset values. A late readdatavalid is ignored. A new start completes normally.

Source files
------------

// File: rtl/slider_moves.sv
// rtl/slider_moves.sv - ray-walking rook/bishop/queen/king move generator over an SDRAM board image
// Define SLIDER_PERF_CNT_EN to add the busy-cycle counter at register 5.
module slider_moves #(
    parameter int BOARD_W   = 8,
    parameter int MAX_MOVES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    localparam int SQ_W  = $clog2(BOARD_W * BOARD_W);
    localparam int RC_W  = $clog2(BOARD_W);
    localparam int CNT_W = $clog2(MAX_MOVES + 1);
    localparam logic [RC_W:0]    BW_C  = (RC_W + 1)'(BOARD_W);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MOVES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_NEXT_DIR = 3'd1;
    localparam logic [2:0] S_STEP     = 3'd2;
    localparam logic [2:0] S_RD_REQ   = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_WR_REQ   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]       state;
    logic             busy, done, overflow, capture;
    logic [31:0]      board_base, out_base;
    logic [SQ_W-1:0]  src_sq, cur_sq, sq_next;
    logic [1:0]       mode;
    logic             colour;
    logic [CNT_W-1:0] count, count_inc;
    logic [3:0]       dir_ptr;
    logic [2:0]       cur_dir;
    logic [RC_W-1:0]  cur_row, cur_col, src_row, src_col;
    logic [1:0]       dr, dc;
    logic signed [RC_W+1:0] nrow, ncol;
    logic             off_board, dir_in_set, is_king, start_req, is_empty, is_enemy;
    logic [7:0]       from8, to8;

    assign slave_waitrequest = 1'b0;
    assign start_req = slave_write && (slave_address == 4'd0) && slave_writedata[0] && !busy;
    assign is_king   = (mode == 2'd3);
    assign count_inc = count + CNT_W'(1);
    assign src_row   = RC_W'(32'(src_sq) / BOARD_W);
    assign src_col   = RC_W'(32'(src_sq) % BOARD_W);
    assign from8     = 8'(src_sq);
    assign to8       = 8'(cur_sq);
    assign is_empty  = (master_readdata == 32'd0);
    assign is_enemy  = master_readdata[3] != colour;

    // Direction index 0..7 is N, NE, E, SE, S, SW, W, NW; deltas are 2-bit two's complement.
    always_comb begin
        dr = 2'b00;
        dc = 2'b00;
        case (cur_dir)
            3'd0:    dr = 2'b01;
            3'd1:    begin dr = 2'b01; dc = 2'b01; end
            3'd2:    dc = 2'b01;
            3'd3:    begin dr = 2'b11; dc = 2'b01; end
            3'd4:    dr = 2'b11;
            3'd5:    begin dr = 2'b11; dc = 2'b11; end
            3'd6:    dc = 2'b11;
            default: begin dr = 2'b01; dc = 2'b11; end
        endcase
    end

    always_comb begin
        case (mode)
            2'd0:    dir_in_set = ~dir_ptr[0];
            2'd1:    dir_in_set = dir_ptr[0];
            default: dir_in_set = 1'b1;
        endcase
    end

    assign nrow = $signed({2'b00, cur_row}) + $signed({{RC_W{dr[1]}}, dr});
    assign ncol = $signed({2'b00, cur_col}) + $signed({{RC_W{dc[1]}}, dc});
    assign off_board = nrow[RC_W+1] || ncol[RC_W+1] ||
                       (nrow[RC_W:0] >= BW_C) || (ncol[RC_W:0] >= BW_C);
    assign sq_next = SQ_W'(32'(nrow[RC_W-1:0]) * BOARD_W + 32'(ncol[RC_W-1:0]));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            capture          <= 1'b0;
            board_base       <= '0;
            out_base         <= '0;
            src_sq           <= '0;
            cur_sq           <= '0;
            mode             <= '0;
            colour           <= 1'b0;
            count            <= '0;
            dir_ptr          <= '0;
            cur_dir          <= '0;
            cur_row          <= '0;
            cur_col          <= '0;
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else begin
            if (slave_write && !busy) begin
                case (slave_address)
                    4'd1: board_base <= slave_writedata;
                    4'd2: out_base   <= slave_writedata;
                    4'd3: begin
                        src_sq <= slave_writedata[SQ_W-1:0];
                        mode   <= slave_writedata[9:8];
                        colour <= slave_writedata[12];
                    end
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        count    <= '0;
                        dir_ptr  <= '0;
                        state    <= S_NEXT_DIR;
                    end
                end
                S_NEXT_DIR: begin
                    if (dir_ptr[3]) begin
                        state <= S_DONE;
                    end else begin
                        dir_ptr <= dir_ptr + 4'd1;
                        if (dir_in_set) begin
                            cur_dir <= dir_ptr[2:0];
                            cur_row <= src_row;
                            cur_col <= src_col;
                            state   <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    if (off_board) begin
                        state <= S_NEXT_DIR;
                    end else begin
                        cur_row        <= nrow[RC_W-1:0];
                        cur_col        <= ncol[RC_W-1:0];
                        cur_sq         <= sq_next;
                        master_address <= board_base + (32'(sq_next) << 2);
                        master_read    <= 1'b1;
                        state          <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        if (is_empty || is_enemy) begin
                            capture          <= !is_empty;
                            master_write     <= 1'b1;
                            master_address   <= out_base + (32'(count) << 2);
                            master_writedata <= {15'b0, !is_empty, from8, to8};
                            state            <= S_WR_REQ;
                        end else begin
                            state <= S_NEXT_DIR;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        count        <= count_inc;
                        if (count_inc == MAX_C) begin
                            overflow <= 1'b1;
                            state    <= S_DONE;
                        end else if (capture || is_king) begin
                            state <= S_NEXT_DIR;
                        end else begin
                            state <= S_STEP;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SLIDER_PERF_CNT_EN
    logic [31:0] cycles;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cycles <= '0;
        end else if (start_req) begin
            cycles <= '0;
        end else if (busy) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            4'd0: slave_readdata = {29'b0, overflow, done, busy};
            4'd1: slave_readdata = board_base;
            4'd2: slave_readdata = out_base;
            4'd3: begin
                slave_readdata[SQ_W-1:0] = src_sq;
                slave_readdata[9:8]      = mode;
                slave_readdata[12]       = colour;
            end
            4'd4: slave_readdata = 32'(count);
`ifdef SLIDER_PERF_CNT_EN
            4'd5: slave_readdata = cycles;
`endif
            default: slave_readdata = '0;
        endcase
    end

    // The register interface has no read side effects.
    logic unused_ok;
    assign unused_ok = slave_read;
endmodule

// File: tb/tb_slider_moves.sv
// tb/tb_slider_moves.sv - randomized bench for slider_moves against a ray-walking reference model
module tb_slider_moves;
    localparam int BW  = 8;
    localparam int NSQ = BW * BW;
    localparam logic [31:0] BOARD_BASE = 32'h0000_1000;
    localparam logic [31:0] OUT_BASE   = 32'h0000_8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        s_write = '0;
    logic [1:0][3:0]   s_addr  = '0;
    logic [1:0][31:0]  s_wdata = '0;
    logic [1:0][31:0]  s_rdata;
    logic [1:0]        s_wait;
    logic [1:0]        m_read, m_write;
    logic [1:0][31:0]  m_addr, m_wdata;

    logic [31:0] board [NSQ];
    int  rd_lat   = 1;
    bit  stall_en = 1'b0;
    int  nrd [2];
    int  nwr [2];
    int  stab_err [2];
    logic [31:0] wr_addr [2][256];
    logic [31:0] wr_data [2][256];

    int checks = 0;
    int errors = 0;
    int exp_w[$];
    int exp_reads;
    bit exp_ovf;
    int rd_base, wr_base, stab_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - BOARD_BASE) >> 2;
        if (addr < BOARD_BASE || addr[1:0] != 2'b00 || idx >= 32'(NSQ)) return 32'hBAD0_BAD0;
        return board[idx];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic        wait_r  = 1'b0;
        logic        rdv_r   = 1'b0;
        logic [31:0] rdata_r = '0;
        int          pend_cnt = 0;
        logic [31:0] pend_data = '0;
        logic        hold_rd = 1'b0, hold_wr = 1'b0, w;
        logic [31:0] hold_addr = '0, hold_data = '0;

        slider_moves #(.BOARD_W(BW), .MAX_MOVES(g == 0 ? 32 : 8)) u_dut (
            .clk                  (clk),
            .rst_n                (rst),
            .slave_waitrequest    (s_wait[g]),
            .slave_address        (s_addr[g]),
            .slave_read           (1'b0),
            .slave_readdata       (s_rdata[g]),
            .slave_write          (s_write[g]),
            .slave_writedata      (s_wdata[g]),
            .master_waitrequest   (wait_r),
            .master_address       (m_addr[g]),
            .master_read          (m_read[g]),
            .master_readdata      (rdata_r),
            .master_readdatavalid (rdv_r),
            .master_write         (m_write[g]),
            .master_writedata     (m_wdata[g])
        );

        initial begin
            nrd[g] = 0;
            nwr[g] = 0;
            stab_err[g] = 0;
        end

        // SDRAM model: random stalls, fixed read latency, one response per accepted read.
        always @(negedge clk) begin
            rdv_r = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rdv_r   = 1'b1;
                    rdata_r = pend_data;
                end
            end
            if (hold_rd && (!m_read[g] || m_addr[g] !== hold_addr)) stab_err[g]++;
            if (hold_wr && (!m_write[g] || m_addr[g] !== hold_addr || m_wdata[g] !== hold_data)) stab_err[g]++;
            w = stall_en && ($urandom_range(0, 1) == 1);
            wait_r    = w;
            hold_rd   = m_read[g] && w;
            hold_wr   = m_write[g] && w;
            hold_addr = m_addr[g];
            hold_data = m_wdata[g];
            if (m_read[g] && !w) begin
                nrd[g]++;
                pend_cnt  = rd_lat;
                pend_data = mem_word(m_addr[g]);
            end
            if (m_write[g] && !w) begin
                wr_addr[g][nwr[g] % 256] = m_addr[g];
                wr_data[g][nwr[g] % 256] = m_wdata[g];
                nwr[g]++;
            end
        end
    end

    task automatic reg_wr(input int g, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_addr[g]  = a;
        s_wdata[g] = d;
        s_write[g] = 1'b1;
        @(negedge clk);
        s_write[g] = 1'b0;
    endtask

    task automatic reg_rd(input int g, input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_addr[g] = a;
        #1 d = s_rdata[g];
    endtask

    // Reference: walk each ray of the mode's direction set with plain integer coordinates.
    task automatic model(input int sq, input int mode, input int col, input int maxm);
        int dr[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
        int dc[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        int r, c;
        logic [31:0] word;
        bit cap;
        exp_w.delete();
        exp_reads = 0;
        exp_ovf = 1'b0;
        for (int d = 0; d < 8; d++) begin
            if (mode == 0 && d % 2 == 1) continue;
            if (mode == 1 && d % 2 == 0) continue;
            r = sq / BW;
            c = sq % BW;
            while (1) begin
                r += dr[d];
                c += dc[d];
                if (r < 0 || r >= BW || c < 0 || c >= BW) break;
                exp_reads++;
                word = board[r * BW + c];
                cap = (word != 0);
                if (cap && word[3] == col[0]) break;
                exp_w.push_back((int'(cap) << 16) | (sq << 8) | (r * BW + c));
                if (exp_w.size() == maxm) begin
                    exp_ovf = 1'b1;
                    return;
                end
                if (cap || mode == 3) break;
            end
        end
    endtask

    task automatic start_case(input int g, input int sq, input int mode, input int col, input bit stall);
        model(sq, mode, col, (g == 0) ? 32 : 8);
        reg_wr(g, 4'd1, BOARD_BASE);
        reg_wr(g, 4'd2, OUT_BASE);
        reg_wr(g, 4'd3, {19'b0, col[0], 2'b0, mode[1:0], 2'b0, sq[5:0]});
        stall_en  = stall;
        rd_base   = nrd[g];
        wr_base   = nwr[g];
        stab_base = stab_err[g];
        reg_wr(g, 4'd0, 32'd1);
    endtask

    task automatic finish_case(input int g, input string tag);
        logic [31:0] st, v;
        st = 32'd1;
        for (int k = 0; k < 4000 && st[0]; k++) reg_rd(g, 4'd0, st);
        stall_en = 1'b0;
        check({tag, " busy_timeout"}, 32'(st[0]), 32'd0);
        check({tag, " status"}, st, {29'b0, exp_ovf, 1'b1, 1'b0});
        reg_rd(g, 4'd4, v);
        check({tag, " count"}, v, 32'(exp_w.size()));
        check({tag, " writes"}, 32'(nwr[g] - wr_base), 32'(exp_w.size()));
        check({tag, " reads"}, 32'(nrd[g] - rd_base), 32'(exp_reads));
        check({tag, " stall_stable"}, 32'(stab_err[g] - stab_base), 32'd0);
        for (int i = 0; i < exp_w.size(); i++) begin
            check({tag, " wr_addr"}, wr_addr[g][(wr_base + i) % 256], OUT_BASE + 32'(4 * i));
            check({tag, " wr_data"}, wr_data[g][(wr_base + i) % 256], 32'(exp_w[i]));
        end
    endtask

    task automatic run_case(input int g, input int sq, input int mode, input int col, input bit stall,
                            input string tag);
        start_case(g, sq, mode, col, stall);
        finish_case(g, tag);
    endtask

    initial begin
        logic [31:0] v;
        int k, rd_snap, wr_snap;
        for (int i = 0; i < NSQ; i++) board[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("reset m_read", 32'(m_read[g]), 32'd0);
            check("reset m_write", 32'(m_write[g]), 32'd0);
            check("reset m_addr", m_addr[g], 32'd0);
            check("reset m_wdata", m_wdata[g], 32'd0);
            check("reset waitrequest", 32'(s_wait[g]), 32'd0);
            reg_rd(g, 4'd0, v);
            check("reset status", v, 32'd0);
            reg_rd(g, 4'd4, v);
            check("reset count", v, 32'd0);
        end

        run_case(0, 0, 0, 0, 1'b0, "rook_empty");
        check("rook_empty n14", 32'(nwr[0] - wr_base), 32'd14);
        check("rook_empty first", wr_data[0][wr_base % 256], 32'h0000_0008);
        check("rook_empty first_addr", wr_addr[0][wr_base % 256], OUT_BASE);

        run_case(0, 27, 2, 0, 1'b0, "queen_empty");
        check("queen_empty n27", 32'(nwr[0] - wr_base), 32'd27);
        check("queen_empty r27", 32'(nrd[0] - rd_base), 32'd27);

        board[8] = 32'h8;
        board[1] = 32'h1;
        run_case(0, 0, 0, 0, 1'b0, "rook_blocked");
        check("rook_blocked word", wr_data[0][wr_base % 256], 32'h0001_0008);
        board[8] = '0;
        board[1] = '0;

        run_case(1, 27, 2, 0, 1'b0, "queen_ovf");
        reg_rd(1, 4'd0, v);
        check("queen_ovf status", v, 32'd6);
        rd_snap = nrd[1];
        wr_snap = nwr[1];
        repeat (20) @(negedge clk);
        check("queen_ovf quiet_rd", 32'(nrd[1] - rd_snap), 32'd0);
        check("queen_ovf quiet_wr", 32'(nwr[1] - wr_snap), 32'd0);
        check("queen_ovf strobes", {30'b0, m_read[1], m_write[1]}, 32'd0);

        run_case(0, 0, 3, 0, 1'b1, "king_stall");
        check("king to8", wr_data[0][wr_base % 256], 32'h0000_0008);
        check("king to9", wr_data[0][(wr_base + 1) % 256], 32'h0000_0009);
        check("king to1", wr_data[0][(wr_base + 2) % 256], 32'h0000_0001);

        start_case(0, 36, 1, 1, 1'b0);
        reg_wr(0, 4'd3, 32'h0000_0305);
        reg_wr(0, 4'd1, 32'h0000_0000);
        reg_wr(0, 4'd0, 32'd1);
        finish_case(0, "bishop_busy_wr");
        reg_rd(0, 4'd3, v);
        check("cfg kept", v, {19'b0, 1'b1, 2'b0, 2'd1, 2'b0, 6'd36});
        reg_rd(0, 4'd1, v);
        check("base kept", v, BOARD_BASE);

        rd_lat = 6;
        start_case(0, 27, 2, 0, 1'b0);
        k = 0;
        while (nrd[0] == rd_base && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst read_seen", 32'(nrd[0] - rd_base), 32'd1);
        @(negedge clk);
        s_addr[0] = 4'd0;
        rst = 1'b1;
        @(negedge clk);
        check("rst m_read", 32'(m_read[0]), 32'd0);
        check("rst m_write", 32'(m_write[0]), 32'd0);
        check("rst m_addr", m_addr[0], 32'd0);
        check("rst m_wdata", m_wdata[0], 32'd0);
        check("rst status", s_rdata[0], 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        reg_rd(0, 4'd0, v);
        check("rst late_status", v, 32'd0);
        reg_rd(0, 4'd4, v);
        check("rst late_count", v, 32'd0);
        check("rst late_strobes", {30'b0, m_read[0], m_write[0]}, 32'd0);
        rd_lat = 1;
        run_case(0, 27, 2, 0, 1'b0, "after_rst");

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NSQ; i++)
                board[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : 32'd0;
            rd_lat = $urandom_range(1, 3);
            run_case(it % 2, $urandom_range(0, NSQ - 1), $urandom_range(0, 3), $urandom_range(0, 1),
                     1'($urandom_range(0, 1)), "random");
        end

`ifndef SLIDER_PERF_CNT_EN
        reg_rd(0, 4'd5, v);
        check("cycles absent", v, 32'd0);
`endif
        reg_rd(0, 4'd6, v);
        check("reg6 zero", v, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
